// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 slave responder over a dual-port RAM, independent read/write burst engines
module axi_mem_slave #(
    parameter int C_S00_AXI_ID_WIDTH   = 1,
    parameter int C_S00_AXI_ADDR_WIDTH = 32,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2       = 10
) (
    input  logic                              ap_clk,
    input  logic                              areset,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
    input  logic [7:0]                        s00_axi_awlen,
    input  logic [2:0]                        s00_axi_awsize,
    input  logic [1:0]                        s00_axi_awburst,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wlast,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
    output logic [1:0]                        s00_axi_bresp,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
    input  logic [7:0]                        s00_axi_arlen,
    input  logic [2:0]                        s00_axi_arsize,
    input  logic [1:0]                        s00_axi_arburst,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rlast
);
    localparam int DW       = C_S00_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IW       = C_S00_AXI_ID_WIDTH;
    localparam int L        = MEM_DEPTH_LOG2;
    localparam logic [2:0] SIZE_FULL = 3'(ADDR_LSB);

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;

    logic [DW-1:0] mem [1<<L];

    logic [1:0]    w_state_q, w_state_d;
    logic [L-1:0]  widx_q, widx_d;
    logic [IW-1:0] wid_q, wid_d;
    logic [7:0]    wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic          werr_q, werr_d, wincr_q, wincr_d;
    logic          mem_we, wlast_bad;

    logic [1:0]    r_state_q, r_state_d;
    logic [L-1:0]  ridx_q, ridx_d;
    logic [IW-1:0] rid_q, rid_d;
    logic [7:0]    rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic          rerr_q, rerr_d, rincr_q, rincr_d, rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q;
    logic          ram_re;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{s00_axi_awaddr, s00_axi_araddr};

    // Ready/valid come only from state registers, masked during reset.
    assign s00_axi_awready = (w_state_q == W_IDLE) && !areset;
    assign s00_axi_wready  = (w_state_q == W_DATA) && !areset;
    assign s00_axi_bvalid  = (w_state_q == W_RESP) && !areset;
    assign s00_axi_bid     = wid_q;
    assign s00_axi_bresp   = ((w_state_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;
    assign s00_axi_arready = (r_state_q == R_IDLE) && !areset;
    assign s00_axi_rvalid  = (r_state_q == R_DATA) && !areset;
    assign s00_axi_rlast   = rlast_q && (r_state_q == R_DATA) && !areset;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rid     = rid_q;
    assign s00_axi_rresp   = rresp_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign b_hs  = s00_axi_bvalid && s00_axi_bready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;
    assign r_hs  = s00_axi_rvalid && s00_axi_rready;

    always_comb begin
        w_state_d = w_state_q;
        widx_d    = widx_q;
        wid_d     = wid_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        wincr_d   = wincr_q;
        mem_we    = 1'b0;
        wlast_bad = 1'b0;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                widx_d    = s00_axi_awaddr[ADDR_LSB +: L];
                wid_d     = s00_axi_awid;
                wlen_d    = s00_axi_awlen;
                wcnt_d    = 8'd0;
                werr_d    = !((s00_axi_awburst == 2'b01 || s00_axi_awburst == 2'b00)
                              && s00_axi_awsize == SIZE_FULL);
                wincr_d   = (s00_axi_awburst == 2'b01);
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                // A misplaced wlast poisons this beat and the rest; length still comes from awlen.
                wlast_bad = s00_axi_wlast != (wcnt_q == wlen_q);
                mem_we    = !werr_q && !wlast_bad;
                werr_d    = werr_q || wlast_bad;
                wcnt_d    = wcnt_q + 8'd1;
                if (wincr_q) widx_d = widx_q + 1'b1;
                if (wcnt_q == wlen_q) w_state_d = W_RESP;
            end
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ridx_d    = ridx_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rincr_d   = rincr_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                ridx_d    = s00_axi_araddr[ADDR_LSB +: L];
                rid_d     = s00_axi_arid;
                rlen_d    = s00_axi_arlen;
                rcnt_d    = 8'd0;
                rerr_d    = !((s00_axi_arburst == 2'b01 || s00_axi_arburst == 2'b00)
                              && s00_axi_arsize == SIZE_FULL);
                rincr_d   = (s00_axi_arburst == 2'b01);
                r_state_d = R_FETCH;
            end
            R_FETCH: begin
                ram_re    = 1'b1;
                rlast_d   = (rlen_q == 8'd0);
                rresp_d   = rerr_q ? 2'b10 : 2'b00;
                r_state_d = R_DATA;
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    ram_re  = 1'b1;
                    rcnt_d  = rcnt_q + 8'd1;
                    rlast_d = (rcnt_q + 8'd1 == rlen_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (ram_re && rincr_q) ridx_d = ridx_q + 1'b1;
    end

    // RAM ports: the read register samples pre-write contents on a same-word collision.
    always_ff @(posedge ap_clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s00_axi_wstrb[b]) mem[widx_q][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rdata_q <= '0;
        end else if (ram_re) begin
            rdata_q <= rerr_q ? '0 : mem[ridx_q];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            widx_q    <= '0;
            wid_q     <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            wincr_q   <= 1'b0;
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            rincr_q   <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            widx_q    <= widx_d;
            wid_q     <= wid_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            wincr_q   <= wincr_d;
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rid_q     <= rid_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            rincr_q   <= rincr_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed scoreboard bench for axi_mem_slave
module tb_axi_mem_slave;
    logic        ap_clk, areset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [0:0]  awid, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    axi_mem_slave dut (
        .ap_clk(ap_clk), .areset(areset),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready), .s00_axi_awaddr(awaddr),
        .s00_axi_awid(awid), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
        .s00_axi_awburst(awburst), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_bid(bid),
        .s00_axi_bresp(bresp), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_araddr(araddr), .s00_axi_arid(arid), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .s00_axi_rdata(rdata), .s00_axi_rid(rid),
        .s00_axi_rresp(rresp), .s00_axi_rlast(rlast)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_q[$];
    logic [31:0] model [1024];
    int          n_assert = 0;
    int          n_fail   = 0;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input logic id, input logic [31:0] base,
                               input logic [3:0] strb, input int early, input int abort_after,
                               input logic [1:0] exp_resp);
        logic [9:0] idx;
        logic       err;
        int         n;
        err = !(burst == 2'b00 || burst == 2'b01) || size != 3'd2;
        idx = addr[11:2];
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awid = id;
        n = 0;
        @(negedge ap_clk);
        while (!awready && n < 20) begin @(negedge ap_clk); n++; end
        if (!awready) check("aw_timeout", 64'(n), 64'd0);
        @(posedge ap_clk); #1 awvalid = 1'b0;
        for (int beat = 0; beat <= len; beat++) begin
            if (beat == abort_after) break;
            wvalid = 1'b1; wdata = base + 32'(beat); wstrb = strb;
            wlast = (beat == len) || (beat == early);
            n = 0;
            @(negedge ap_clk);
            while (!wready && n < 20) begin @(negedge ap_clk); n++; end
            if (!wready) check("w_timeout", 64'(n), 64'd0);
            @(posedge ap_clk); #1;
            if (!err && early < 0) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (burst == 2'b01) idx++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (abort_after >= 0) begin
            areset = 1'b1;
            @(posedge ap_clk); #1 areset = 1'b0;
            @(negedge ap_clk);
            check("rst_awready", 64'(awready), 64'd1);
            for (int c = 0; c < 4; c++) begin
                check("rst_no_bvalid", 64'(bvalid), 64'd0);
                @(negedge ap_clk);
            end
            @(posedge ap_clk); #1;
            return;
        end
        bready = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!bvalid && n < 20) begin @(negedge ap_clk); n++; end
        check("bvalid", 64'(bvalid), 64'd1);
        check("bresp", 64'(bresp), 64'(exp_resp));
        check("bid", 64'(bid), 64'(id));
        @(posedge ap_clk); #1 bready = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic id, input logic toggle);
        logic [9:0]  idx;
        logic        err, stalled;
        logic [34:0] held;
        rbeat_t      e;
        int          n;
        err = !(burst == 2'b00 || burst == 2'b01) || size != 3'd2;
        idx = addr[11:2];
        for (int i = 0; i <= len; i++) begin
            e.data = err ? 32'h0 : model[idx];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_q.push_back(e);
            if (burst == 2'b01) idx++;
        end
        rready = 1'b1;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id;
        n = 0;
        @(negedge ap_clk);
        while (!arready && n < 20) begin @(negedge ap_clk); n++; end
        @(posedge ap_clk); #1 arvalid = 1'b0;
        n = 0;
        do begin @(negedge ap_clk); n++; end while (!rvalid && n < 10);
        check("rd_first_latency", 64'(n), 64'd2);
        stalled = 1'b0; held = '0; n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            if (rvalid) begin
                if (stalled) check("rd_hold", {rdata, rresp, rlast}, held);
                if (rready) begin
                    e = exp_q.pop_front();
                    check("rd_data", 64'(rdata), 64'(e.data));
                    check("rd_resp", 64'(rresp), 64'(e.resp));
                    check("rd_last", 64'(rlast), 64'(e.last));
                    check("rd_id", 64'(rid), 64'(id));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {rdata, rresp, rlast};
                end
            end
            if (exp_q.size() == 0) break;
            @(posedge ap_clk); #1;
            if (toggle) rready = ~rready;
            @(negedge ap_clk); n++;
        end
        if (exp_q.size() != 0) check("rd_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        check("rd_back_idle", {rvalid, arready}, 64'b01);
        @(posedge ap_clk); #1;
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

        @(negedge ap_clk);
        check("reset_ctrl", {awready, arready, wready, bvalid, rvalid, rlast}, 64'd0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("reset_data", {bresp, rresp, bid, rid, rdata}, 64'd0);
        @(posedge ap_clk); #1 areset = 1'b0;

        write_burst(32'h100, 3, 3'd2, 2'b01, 1'b1, 32'hA0, 4'hF, -1, -1, 2'b00);
        read_burst(32'h100, 3, 3'd2, 2'b01, 1'b1, 1'b0);
        read_burst(32'h100, 2, 3'd2, 2'b00, 1'b0, 1'b0);

        write_burst(32'h40, 0, 3'd2, 2'b01, 1'b0, 32'hFFFFFFFF, 4'hF, -1, -1, 2'b00);
        write_burst(32'h40, 0, 3'd2, 2'b01, 1'b0, 32'h12345678, 4'h5, -1, -1, 2'b00);
        read_burst(32'h40, 0, 3'd2, 2'b01, 1'b0, 1'b0);

        write_burst(32'h180, 7, 3'd2, 2'b01, 1'b0, 32'hC0, 4'hF, -1, -1, 2'b00);
        read_burst(32'h180, 7, 3'd2, 2'b01, 1'b1, 1'b1);

        write_burst(32'h200, 3, 3'd2, 2'b01, 1'b0, 32'h70, 4'hF, -1, -1, 2'b00);
        write_burst(32'h200, 3, 3'd2, 2'b10, 1'b1, 32'h90, 4'hF, -1, -1, 2'b10);
        read_burst(32'h200, 3, 3'd2, 2'b01, 1'b0, 1'b0);
        read_burst(32'h100, 3, 3'd1, 2'b01, 1'b1, 1'b0);
        write_burst(32'h300, 3, 3'd2, 2'b01, 1'b0, 32'hB0, 4'hF, 1, -1, 2'b10);

        write_burst(32'h80, 0, 3'd2, 2'b01, 1'b0, 32'h11, 4'hF, -1, -1, 2'b00);
        fork
            write_burst(32'h80, 0, 3'd2, 2'b01, 1'b1, 32'h22, 4'hF, -1, -1, 2'b00);
            read_burst(32'h80, 0, 3'd2, 2'b01, 1'b0, 1'b0);
        join
        read_burst(32'h80, 0, 3'd2, 2'b01, 1'b0, 1'b0);

        write_burst(32'h0, 3, 3'd2, 2'b01, 1'b0, 32'h50, 4'hF, -1, -1, 2'b00);
        write_burst(32'h0, 3, 3'd2, 2'b01, 1'b1, 32'h60, 4'hF, -1, 2, 2'b00);
        read_burst(32'h0, 3, 3'd2, 2'b01, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
